spi_slave_mem_if: RTL and testbench

//  SPI slave (mode 0, CS active-low, LSB-first bits) that terminates frames from our SPI master.

---
 rtl/spi_slave_mem_if.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_slave_mem_if.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mem_if.sv
// spi_slave_mem_if: SPI mode-0 slave that turns LSB-first command frames into
// byte-wide memory write/read accesses. The SPI pins are oversampled in the clk
// domain. Frames are: command byte, address bytes LSB first, then data bytes.
// Optional feature macro: SPI_ADDR_AUTOINC_EN (address advances after each
// write strobe and after each read-data latch, wrapping at 2^ADDR_WIDTH).
module spi_slave_mem_if #(
  parameter int         ADDR_WIDTH = 24,
  parameter logic [7:0] CMD_WR     = 8'h02,
  parameter logic [7:0] CMD_RD     = 8'h03,
  parameter int         RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  busy,
  output logic [7:0]            cmd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            wr_data,
  output logic                  wr_vld,
  output logic                  rd_req,
  input  logic [7:0]            rd_data,
  output logic                  frame_done
);

  localparam int NB = ADDR_WIDTH / 8;
  localparam int LW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR    = 3'd2,
    S_WR_DATA = 3'd3,
    S_RD_DATA = 3'd4,
    S_DISCARD = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]              r_sck_sync;
  logic [1:0]              r_cs_sync;
  logic [1:0]              r_mosi_sync;
  logic                    r_sck_d;
  logic                    r_cs_d;
  logic [2:0]              r_bit_cnt;
  logic [7:0]              r_rx;
  logic [2:0]              r_abyte;
  logic [7:0]              r_tx;
  logic [LW-1:0]           r_lat_cnt;
  logic                    r_miso;
  logic                    r_busy;
  logic [7:0]              r_cmd;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_wr_data;
  logic                    r_wr_vld;
  logic                    r_rd_req;
  logic                    r_frame_done;

  logic                    w_sck_rise;
  logic                    w_sck_fall;
  logic                    w_cs_hi;
  logic                    w_cs_fall;
  logic                    w_byte_done;
  logic [7:0]              w_byte;
  logic                    w_addr_last;
  logic                    w_latch;
  logic [ADDR_WIDTH+7:0]   w_addr_cat;

  assign w_sck_rise  = r_sck_sync[1] & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_sync[1] & r_sck_d;
  assign w_cs_hi     = r_cs_sync[1];
  assign w_cs_fall   = r_cs_d & ~r_cs_sync[1];
  assign w_byte_done = (r_state != S_IDLE) && w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_byte      = {r_mosi_sync[1], r_rx[7:1]};
  assign w_addr_last = (r_abyte == 3'(NB - 1));
  assign w_latch     = (r_lat_cnt == LW'(1));
  // New address byte enters at the top while the rest moves down one byte.
  assign w_addr_cat  = {w_byte, r_addr};

  // Pin synchronisers run free of reset so a reset inside a frame cannot fake a CS edge.
  always_ff @(posedge clk) begin
    r_sck_sync  <= {r_sck_sync[0], spi_sck};
    r_cs_sync   <= {r_cs_sync[0], spi_cs};
    r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
    r_sck_d     <= r_sck_sync[1];
    r_cs_d      <= r_cs_sync[1];
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: frames start only on a CS falling edge, CS high aborts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) w_state_nxt = S_CMD;
        else           w_state_nxt = S_IDLE;
      end
      S_CMD: begin
        if (w_cs_hi)          w_state_nxt = S_IDLE;
        else if (w_byte_done) w_state_nxt = S_ADDR;
        else                  w_state_nxt = S_CMD;
      end
      S_ADDR: begin
        if (w_cs_hi) begin
          w_state_nxt = S_IDLE;
        end else if (w_byte_done && w_addr_last) begin
          if (r_cmd == CMD_WR)      w_state_nxt = S_WR_DATA;
          else if (r_cmd == CMD_RD) w_state_nxt = S_RD_DATA;
          else                      w_state_nxt = S_DISCARD;
        end else begin
          w_state_nxt = S_ADDR;
        end
      end
      S_WR_DATA, S_RD_DATA, S_DISCARD: begin
        if (w_cs_hi) w_state_nxt = S_IDLE;
        else         w_state_nxt = r_state;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Receive path: bit counting, byte assembly and the per-state byte actions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bit_cnt    <= 3'd0;
      r_rx         <= 8'h00;
      r_abyte      <= 3'd0;
      r_cmd        <= 8'h00;
      r_addr       <= '0;
      r_wr_data    <= 8'h00;
      r_wr_vld     <= 1'b0;
      r_rd_req     <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_wr_vld     <= 1'b0;
      r_rd_req     <= 1'b0;
      r_frame_done <= (r_state != S_IDLE) && w_cs_hi;
      r_busy       <= (w_state_nxt != S_IDLE);
      if ((r_state == S_IDLE) || w_cs_hi) begin
        r_bit_cnt <= 3'd0;
      end else if (w_sck_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx      <= w_byte;
      end
`ifdef SPI_ADDR_AUTOINC_EN
      if (r_wr_vld || w_latch) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
`endif
      // A byte finishing together with CS rising is still honoured.
      if (w_byte_done) begin
        case (r_state)
          S_CMD: begin
            r_cmd   <= w_byte;
            r_abyte <= 3'd0;
          end
          S_ADDR: begin
            r_addr   <= w_addr_cat[ADDR_WIDTH+7:8];
            r_abyte  <= r_abyte + 3'd1;
            r_rd_req <= w_addr_last && (r_cmd == CMD_RD);
          end
          S_WR_DATA: begin
            r_wr_data <= w_byte;
            r_wr_vld  <= 1'b1;
          end
          S_RD_DATA: begin
            r_rd_req <= 1'b1;
          end
          default: begin
            r_abyte <= r_abyte;
          end
        endcase
      end
    end
  end

  // Transmit path: fixed-latency read capture and MISO updates on SCK falling edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lat_cnt <= '0;
      r_tx      <= 8'h00;
      r_miso    <= 1'b0;
    end else begin
      if (r_rd_req) begin
        r_lat_cnt <= LW'(RD_LAT);
      end else if (r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - LW'(1);
      end
      if (w_latch) begin
        r_tx <= rd_data;
      end else if (w_sck_fall && (r_state == S_RD_DATA)) begin
        r_tx <= {1'b0, r_tx[7:1]};
      end
      if ((r_state != S_RD_DATA) || w_cs_hi) begin
        r_miso <= 1'b0;
      end else if (w_sck_fall) begin
        r_miso <= r_tx[0];
      end
    end
  end

  assign spi_miso   = r_miso;
  assign busy       = r_busy;
  assign cmd        = r_cmd;
  assign addr       = r_addr;
  assign wr_data    = r_wr_data;
  assign wr_vld     = r_wr_vld;
  assign rd_req     = r_rd_req;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_spi_slave_mem_if.sv
// Randomised frame-level bench for spi_slave_mem_if. A behavioural master
// shifts whole frames; a reference model predicts the memory accesses, the
// MISO bytes and the frame strobes from the command/address/data of each frame.
module tb_spi_slave_mem_if;
  localparam int RD_LAT = 2;
  localparam int HALF   = 8;
`ifdef SPI_ADDR_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        sck  = 1'b0;
  logic        cs   = 1'b1;
  logic        mosi = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        miso, busy, wr_vld, rd_req, frame_done;
  logic [7:0]  cmd, wr_data;
  logic [23:0] addr;

  spi_slave_mem_if #(.ADDR_WIDTH(24), .CMD_WR(8'h02), .CMD_RD(8'h03), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_cs(cs), .spi_mosi(mosi),
    .spi_miso(miso), .busy(busy), .cmd(cmd), .addr(addr), .wr_data(wr_data),
    .wr_vld(wr_vld), .rd_req(rd_req), .rd_data(rd_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Observed activity and the user-memory responder.
  logic [23:0] obs_wr_addr[$];
  logic [7:0]  obs_wr_data[$];
  logic [23:0] obs_rd_addr[$];
  logic [7:0]  rd_src[$];
  int          obs_fd  = 0;
  int          lat_cnt = 0;
  logic [7:0]  rd_pend = 8'h00;

  // Collect strobes; present read data only in the single cycle it is due.
  always @(negedge clk) begin
    if (wr_vld) begin
      obs_wr_addr.push_back(addr);
      obs_wr_data.push_back(wr_data);
    end
    if (frame_done) obs_fd++;
    if (lat_cnt == 1) begin
      rd_data = rd_pend;
      lat_cnt = 0;
    end else begin
      rd_data = 8'($urandom);
      if (lat_cnt > 1) lat_cnt--;
    end
    if (rd_req) begin
      obs_rd_addr.push_back(addr);
      rd_pend = (rd_src.size() > 0) ? rd_src.pop_front() : 8'h00;
      lat_cnt = RD_LAT;
    end
  end

  logic [7:0] tx_q[4];
  logic [7:0] rd_q[4];
  logic [7:0] rx_q[4];

  // Shift nb bits LSB first in SPI mode 0, capturing MISO on each rising SCK.
  task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nb; i++) begin
      mosi = b[i];
      repeat (HALF) @(posedge clk);
      #1;
      sck  = 1'b1;
      r[i] = miso;
      repeat (HALF) @(posedge clk);
      #1;
      sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [23:0] a, input int n, input int part);
    logic [7:0] d;
    cs = 1'b0;
    repeat (HALF) @(posedge clk);
    spi_bits(c, 8, d);
    for (int k = 0; k < 3; k++) spi_bits(a[8*k +: 8], 8, d);
    for (int k = 0; k < n; k++) spi_bits(tx_q[k], 8, rx_q[k]);
    if (part > 0) spi_bits(8'($urandom), part, d);
    repeat (HALF) @(posedge clk);
    cs = 1'b1;
    repeat (4 * HALF) @(posedge clk);
  endtask

  // Run one frame and compare against what the frame's rules predict.
  task automatic run_check(input string nm, input logic [7:0] c, input logic [23:0] a,
                           input int n, input int part);
    int nrd;
    int nadv;
    obs_wr_addr.delete();
    obs_wr_data.delete();
    obs_rd_addr.delete();
    rd_src.delete();
    obs_fd = 0;
    for (int k = 0; k <= n; k++) rd_src.push_back(rd_q[k]);
    send_frame(c, a, n, part);
    @(negedge clk);
    check_val({nm, ".frame_done"}, 32'(obs_fd), 32'd1);
    check_val({nm, ".cmd"}, {24'h0, cmd}, {24'h0, c});
    check_val({nm, ".busy"}, {31'h0, busy}, 32'd0);
    if (c == 8'h02) begin
      check_val({nm, ".wr_cnt"}, 32'(obs_wr_addr.size()), 32'(n));
      for (int k = 0; k < n && k < obs_wr_addr.size(); k++) begin
        check_val({nm, ".wr_addr"}, {8'h0, obs_wr_addr[k]}, {8'h0, 24'(a + 24'(k * INC))});
        check_val({nm, ".wr_data"}, {24'h0, obs_wr_data[k]}, {24'h0, tx_q[k]});
      end
    end else begin
      check_val({nm, ".no_wr"}, 32'(obs_wr_addr.size()), 32'd0);
    end
    if (c == 8'h03) begin
      // One request at the end of the address, then one per clocked data byte.
      nrd = n + 1;
      check_val({nm, ".rd_cnt"}, 32'(obs_rd_addr.size()), 32'(nrd));
      for (int k = 0; k < nrd && k < obs_rd_addr.size(); k++)
        check_val({nm, ".rd_addr"}, {8'h0, obs_rd_addr[k]}, {8'h0, 24'(a + 24'(k * INC))});
      for (int k = 0; k < n; k++)
        check_val({nm, ".miso_byte"}, {24'h0, rx_q[k]}, {24'h0, rd_q[k]});
    end else begin
      check_val({nm, ".no_rd"}, 32'(obs_rd_addr.size()), 32'd0);
      for (int k = 0; k < n; k++)
        check_val({nm, ".miso_zero"}, {24'h0, rx_q[k]}, 32'd0);
    end
    nadv = (c == 8'h02) ? n : ((c == 8'h03) ? n + 1 : 0);
    check_val({nm, ".addr_end"}, {8'h0, addr}, {8'h0, 24'(a + 24'(nadv * INC))});
  endtask

  task automatic check_all_zero(input string nm);
    check_val({nm, ".busy"},       {31'h0, busy},       32'd0);
    check_val({nm, ".cmd"},        {24'h0, cmd},        32'd0);
    check_val({nm, ".addr"},       {8'h0, addr},        32'd0);
    check_val({nm, ".wr_data"},    {24'h0, wr_data},    32'd0);
    check_val({nm, ".wr_vld"},     {31'h0, wr_vld},     32'd0);
    check_val({nm, ".rd_req"},     {31'h0, rd_req},     32'd0);
    check_val({nm, ".frame_done"}, {31'h0, frame_done}, 32'd0);
    check_val({nm, ".miso"},       {31'h0, miso},       32'd0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 4; k++) begin
      tx_q[k] = 8'($urandom);
      rd_q[k] = 8'($urandom);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] c;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (10) @(posedge clk);

    fill_random();
    tx_q[0] = 8'hA5; tx_q[1] = 8'h3C;
    run_check("write", 8'h02, 24'h123456, 2, 0);

    fill_random();
    rd_q[0] = 8'h5A; rd_q[1] = 8'hC3;
    run_check("read", 8'h03, 24'h000010, 2, 0);

    fill_random();
    run_check("unknown", 8'h9F, 24'h00ABCD, 2, 0);

    fill_random();
    run_check("partial", 8'h02, 24'h004400, 1, 4);
    fill_random();
    run_check("after_partial", 8'h02, 24'h000077, 1, 0);

    fill_random();
    run_check("wrap", 8'h02, 24'hFFFFFF, 2, 0);

    // Reset in the middle of the address phase; rest of that frame must be ignored.
    obs_wr_addr.delete();
    obs_wr_data.delete();
    cs = 1'b0;
    repeat (HALF) @(posedge clk);
    spi_bits(8'h02, 8, d);
    spi_bits(8'h11, 8, d);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b1;
    spi_bits(8'h22, 8, d);
    spi_bits(8'h33, 8, d);
    spi_bits(8'h44, 8, d);
    repeat (HALF) @(posedge clk);
    cs = 1'b1;
    repeat (4 * HALF) @(posedge clk);
    check_val("rst_mid.no_wr", 32'(obs_wr_addr.size()), 32'd0);
    fill_random();
    run_check("after_rst", 8'h02, 24'h0A0B0C, 2, 0);

    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 2))
        0:       c = 8'h02;
        1:       c = 8'h03;
        default: c = {1'b1, 7'($urandom)};
      endcase
      fill_random();
      run_check("rand", c, 24'($urandom), int'($urandom_range(1, 3)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
